// File: rtl/ace_pkg.sv
// Shared ACE snoop-channel types and CRRESP bit positions.
// Used by the CCU snoop path.
package ace_pkg;

    typedef logic [3:0] arsnoop_t;
    typedef logic [4:0] crresp_t;
    typedef logic [2:0] acprot_t;

    localparam arsnoop_t ArReadOnce           = 4'b0000;
    localparam arsnoop_t ArReadShared         = 4'b0001;
    localparam arsnoop_t ArReadClean          = 4'b0010;
    localparam arsnoop_t ArReadNotSharedDirty = 4'b0011;
    localparam arsnoop_t ArReadUnique         = 4'b0111;
    localparam arsnoop_t ArCleanShared        = 4'b1000;
    localparam arsnoop_t ArCleanInvalid       = 4'b1001;
    localparam arsnoop_t ArMakeInvalid        = 4'b1101;

    localparam int unsigned CrDataTransfer = 0;
    localparam int unsigned CrError        = 1;
    localparam int unsigned CrPassDirty    = 2;
    localparam int unsigned CrIsShared     = 3;
    localparam int unsigned CrWasUnique    = 4;

    typedef enum logic [1:0] {
        SnIdle  = 2'd0,
        SnSnoop = 2'd1,
        SnResp  = 2'd2
    } snoopState_e;

endpackage

// File: rtl/ace_cr_merge.sv
// Combinational OR-merge of the selected per-port CRRESP values, plus the
// mask of selected ports that signalled DataTransfer.
module ace_cr_merge
    import ace_pkg::*;
#(
    parameter int unsigned NoPorts = 4
) (
    input  logic [NoPorts*5-1:0] crResp,
    input  logic [NoPorts-1:0]   crSel,
    output crresp_t              mergedResp,
    output logic [NoPorts-1:0]   dataMask
);

    always_comb begin
        mergedResp = '0;
        dataMask   = '0;
        for (int unsigned i = 0; i < NoPorts; i++) begin
            if (crSel[i]) begin
                mergedResp  = mergedResp | crResp[5*i +: 5];
                dataMask[i] = crResp[5*i + CrDataTransfer];
            end
        end
    end

endmodule

// File: rtl/ace_snoop_collector.sv
// Broadcasts one snoop to every master except the initiator, then collects
// and merges the CR responses into a single response with a data-port mask.
module ace_snoop_collector
    import ace_pkg::*;
#(
    parameter int unsigned NoPorts   = 4,
    parameter int unsigned AddrWidth = 64,
    parameter int unsigned IdxWidth  = (NoPorts > 1) ? $clog2(NoPorts) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic [AddrWidth-1:0] req_addr_i,
    input  arsnoop_t             req_snoop_i,
    input  acprot_t              req_prot_i,
    input  logic [IdxWidth-1:0]  req_initiator_i,
    output logic [NoPorts-1:0]   ac_valid_o,
    input  logic [NoPorts-1:0]   ac_ready_i,
    output logic [AddrWidth-1:0] ac_addr_o,
    output arsnoop_t             ac_snoop_o,
    output acprot_t              ac_prot_o,
    input  logic [NoPorts-1:0]   cr_valid_i,
    output logic [NoPorts-1:0]   cr_ready_o,
    input  logic [NoPorts*5-1:0] cr_resp_i,
    output logic                 resp_valid_o,
    input  logic                 resp_ready_i,
    output crresp_t              resp_o,
    output logic [NoPorts-1:0]   resp_data_mask_o
);

    snoopState_e          stateQ, stateD;
    logic [AddrWidth-1:0] addrQ, addrD;
    arsnoop_t             snoopQ, snoopD;
    acprot_t              protQ, protD;
    logic [NoPorts-1:0]   targetQ, targetD;
    logic [NoPorts-1:0]   acDoneQ, acDoneD;
    logic [NoPorts-1:0]   crDoneQ, crDoneD;
    crresp_t              accQ, accD;
    logic [NoPorts-1:0]   maskQ, maskD;

    logic [NoPorts-1:0]   reqTarget;
    logic [NoPorts-1:0]   acValid;
    logic [NoPorts-1:0]   crReady;
    logic [NoPorts-1:0]   crHs;
    crresp_t              mergedResp;
    logic [NoPorts-1:0]   mergedMask;

    // An out-of-range initiator index matches no port and so clears no bit.
    always_comb begin
        reqTarget = '0;
        for (int unsigned i = 0; i < NoPorts; i++) begin
            reqTarget[i] = (32'(req_initiator_i) != i);
        end
    end

    assign acValid = (stateQ == SnSnoop) ? (targetQ & ~acDoneQ) : '0;
    assign crReady = (stateQ == SnSnoop) ? (acDoneQ & ~crDoneQ) : '0;
    assign crHs    = crReady & cr_valid_i;

    ace_cr_merge #(
        .NoPorts(NoPorts)
    ) u_crMerge (
        .crResp    (cr_resp_i),
        .crSel     (crHs),
        .mergedResp(mergedResp),
        .dataMask  (mergedMask)
    );

    always_comb begin
        stateD  = stateQ;
        addrD   = addrQ;
        snoopD  = snoopQ;
        protD   = protQ;
        targetD = targetQ;
        acDoneD = acDoneQ;
        crDoneD = crDoneQ;
        accD    = accQ;
        maskD   = maskQ;
        case (stateQ)
            SnIdle: begin
                if (req_valid_i) begin
                    addrD   = req_addr_i;
                    snoopD  = req_snoop_i;
                    protD   = req_prot_i;
                    targetD = reqTarget;
                    acDoneD = '0;
                    crDoneD = '0;
                    accD    = '0;
                    maskD   = '0;
                    stateD  = (reqTarget == '0) ? SnResp : SnSnoop;
                end
            end
            SnSnoop: begin
                acDoneD = acDoneQ | (acValid & ac_ready_i);
                crDoneD = crDoneQ | crHs;
                accD    = accQ | mergedResp;
                maskD   = maskQ | mergedMask;
                // Compare the registered done-mask: RESP follows one cycle
                // after the last CR has been recorded.
                if (crDoneQ == targetQ) begin
                    stateD = SnResp;
                end
            end
            SnResp: begin
                if (resp_ready_i) begin
                    stateD = SnIdle;
                end
            end
            default: stateD = SnIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stateQ  <= SnIdle;
            addrQ   <= '0;
            snoopQ  <= '0;
            protQ   <= '0;
            targetQ <= '0;
            acDoneQ <= '0;
            crDoneQ <= '0;
            accQ    <= '0;
            maskQ   <= '0;
        end else begin
            stateQ  <= stateD;
            addrQ   <= addrD;
            snoopQ  <= snoopD;
            protQ   <= protD;
            targetQ <= targetD;
            acDoneQ <= acDoneD;
            crDoneQ <= crDoneD;
            accQ    <= accD;
            maskQ   <= maskD;
        end
    end

    assign req_ready_o      = (stateQ == SnIdle);
    assign ac_valid_o       = acValid;
    assign ac_addr_o        = addrQ;
    assign ac_snoop_o       = snoopQ;
    assign ac_prot_o        = protQ;
    assign cr_ready_o       = crReady;
    assign resp_valid_o     = (stateQ == SnResp);
    assign resp_o           = (stateQ == SnResp) ? accQ : '0;
    assign resp_data_mask_o = (stateQ == SnResp) ? maskQ : '0;

endmodule

// File: tb/tb_ace_snoop_collector.sv
// Directed bench for ace_snoop_collector: a 4-port and a 1-port instance
// sharing clock and reset.
module tb_ace_snoop_collector;
    import ace_pkg::*;

    logic        clk;
    logic        rstN;

    logic        reqValid;
    logic        reqReady;
    logic [63:0] reqAddr;
    arsnoop_t    reqSnoop;
    acprot_t     reqProt;
    logic [1:0]  reqInit;
    logic [3:0]  acValid;
    logic [3:0]  acReady;
    logic [63:0] acAddr;
    arsnoop_t    acSnoop;
    acprot_t     acProt;
    logic [3:0]  crValid;
    logic [3:0]  crReady;
    logic [19:0] crResp;
    logic        respValid;
    logic        respReady;
    crresp_t     resp;
    logic [3:0]  respMask;

    logic        req1Valid;
    logic        req1Ready;
    logic [63:0] req1Addr;
    logic [0:0]  req1Init;
    logic [0:0]  ac1Valid;
    logic [63:0] ac1Addr;
    arsnoop_t    ac1Snoop;
    acprot_t     ac1Prot;
    logic [0:0]  cr1Ready;
    logic        resp1Valid;
    logic        resp1Ready;
    crresp_t     resp1;
    logic [0:0]  resp1Mask;

    int testCount = 0;
    int failCount = 0;

    ace_snoop_collector #(
        .NoPorts  (4),
        .AddrWidth(64)
    ) dut (
        .clk_i           (clk),
        .rst_ni          (rstN),
        .req_valid_i     (reqValid),
        .req_ready_o     (reqReady),
        .req_addr_i      (reqAddr),
        .req_snoop_i     (reqSnoop),
        .req_prot_i      (reqProt),
        .req_initiator_i (reqInit),
        .ac_valid_o      (acValid),
        .ac_ready_i      (acReady),
        .ac_addr_o       (acAddr),
        .ac_snoop_o      (acSnoop),
        .ac_prot_o       (acProt),
        .cr_valid_i      (crValid),
        .cr_ready_o      (crReady),
        .cr_resp_i       (crResp),
        .resp_valid_o    (respValid),
        .resp_ready_i    (respReady),
        .resp_o          (resp),
        .resp_data_mask_o(respMask)
    );

    ace_snoop_collector #(
        .NoPorts  (1),
        .AddrWidth(64)
    ) dut1 (
        .clk_i           (clk),
        .rst_ni          (rstN),
        .req_valid_i     (req1Valid),
        .req_ready_o     (req1Ready),
        .req_addr_i      (req1Addr),
        .req_snoop_i     (ArReadShared),
        .req_prot_i      (3'b000),
        .req_initiator_i (req1Init),
        .ac_valid_o      (ac1Valid),
        .ac_ready_i      (1'b1),
        .ac_addr_o       (ac1Addr),
        .ac_snoop_o      (ac1Snoop),
        .ac_prot_o       (ac1Prot),
        .cr_valid_i      (1'b1),
        .cr_ready_o      (cr1Ready),
        .cr_resp_i       (5'b01111),
        .resp_valid_o    (resp1Valid),
        .resp_ready_i    (resp1Ready),
        .resp_o          (resp1),
        .resp_data_mask_o(resp1Mask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        testCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change 2 time units after the rising edge; checks follow 1 unit later.
    task automatic nextCycle();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rstN = 1'b0;
        reqValid = 1'b0; reqAddr = '0; reqSnoop = '0; reqProt = '0; reqInit = '0;
        acReady = '0; crValid = '0; crResp = '0; respReady = 1'b0;
        req1Valid = 1'b0; req1Addr = '0; req1Init = '0; resp1Ready = 1'b0;

        // Reset state
        nextCycle(); nextCycle(); #1;
        check("rst_req_ready", reqReady, 1);
        check("rst_ac_valid", acValid, 0);
        check("rst_cr_ready", crReady, 0);
        check("rst_resp_valid", respValid, 0);
        check("rst_resp", resp, 0);
        check("rst_mask", respMask, 0);
        check("rst_ac_addr", acAddr, 0);
        check("rst_ac_snoop", acSnoop, 0);
        check("rst_ac_prot", acProt, 0);
        check("rst1_req_ready", req1Ready, 1);
        rstN = 1'b1;

        // Base case: initiator 0, only port 2 returns data
        nextCycle();
        reqValid = 1'b1; reqInit = 2'd0; reqAddr = 64'h1000; reqSnoop = 4'b0001; reqProt = 3'b010;
        acReady = 4'hF; crValid = 4'hF; crResp = {5'b00000, 5'b01001, 5'b00000, 5'b00000};
        #1;
        check("base_accept_ready", reqReady, 1);
        check("base_accept_acv", acValid, 0);
        nextCycle(); reqValid = 1'b0; #1;
        check("base_ac_valid", acValid, 4'b1110);
        check("base_ac_addr", acAddr, 64'h1000);
        check("base_ac_snoop", acSnoop, 4'b0001);
        check("base_ac_prot", acProt, 3'b010);
        check("base_cr_ready_c1", crReady, 0);
        check("base_req_ready_busy", reqReady, 0);
        nextCycle(); #1;
        check("base_ac_done", acValid, 0);
        check("base_cr_ready", crReady, 4'b1110);
        nextCycle(); #1;
        check("base_cr_done", crReady, 0);
        check("base_resp_wait", respValid, 0);
        nextCycle(); respReady = 1'b1; #1;
        check("base_resp_valid", respValid, 1);
        check("base_resp", resp, 5'b01001);
        check("base_mask", respMask, 4'b0100);
        nextCycle(); respReady = 1'b0; #1;
        check("base_back_idle", respValid, 0);
        check("base_idle_ready", reqReady, 1);

        // Skewed AC: port 3 stalls its AC handshake for 5 cycles
        reqValid = 1'b1; reqInit = 2'd0; reqAddr = 64'hABCD_0040; reqSnoop = 4'b0111; reqProt = 3'b001;
        acReady = 4'b0111; crResp = {5'b10100, 5'b01000, 5'b00001, 5'b00000};
        nextCycle(); reqValid = 1'b0; #1;
        check("skew_ac_valid_c1", acValid, 4'b1110);
        nextCycle(); #1;
        check("skew_ac_valid_c2", acValid, 4'b1000);
        check("skew_cr_ready_c2", crReady, 4'b0110);
        for (int k = 0; k < 3; k++) begin
            nextCycle(); #1;
            check("skew_ac3_held", acValid, 4'b1000);
            check("skew_addr_stable", acAddr, 64'hABCD_0040);
            check("skew_snoop_stable", acSnoop, 4'b0111);
            check("skew_cr3_blocked", crReady, 0);
            check("skew_resp_wait", respValid, 0);
        end
        nextCycle(); acReady = 4'hF; #1;
        check("skew_ac3_last", acValid, 4'b1000);
        check("skew_cr3_before_hs", crReady, 0);
        nextCycle(); #1;
        check("skew_ac_clear", acValid, 0);
        check("skew_cr3_ready", crReady, 4'b1000);
        nextCycle(); #1;
        check("skew_resp_wait2", respValid, 0);
        nextCycle(); respReady = 1'b1; #1;
        check("skew_resp_valid", respValid, 1);
        check("skew_resp", resp, 5'b11101);
        check("skew_mask", respMask, 4'b0010);

        // Merge with error, initiator 1 (its own response must be ignored)
        nextCycle(); respReady = 1'b0;
        reqValid = 1'b1; reqInit = 2'd1; reqAddr = 64'h3000; reqSnoop = 4'b0001; reqProt = 3'b000;
        crResp = {5'b00010, 5'b00101, 5'b01000, 5'b10000};
        #1;
        check("merge_accept_ready", reqReady, 1);
        nextCycle(); reqValid = 1'b0; #1;
        check("merge_ac_valid", acValid, 4'b1101);
        nextCycle(); #1;
        check("merge_cr_ready", crReady, 4'b1101);
        nextCycle(); #1;
        check("merge_resp_wait", respValid, 0);

        // Backpressure with a second request pending
        nextCycle();
        reqValid = 1'b1; reqInit = 2'd3; reqAddr = 64'h2000; reqSnoop = 4'b1001; reqProt = 3'b100;
        #1;
        check("merge_resp_valid", respValid, 1);
        check("merge_resp", resp, 5'b10111);
        check("merge_mask", respMask, 4'b0100);
        check("bp_req_ready_c0", reqReady, 0);
        for (int k = 0; k < 2; k++) begin
            nextCycle(); #1;
            check("bp_resp_valid", respValid, 1);
            check("bp_resp_stable", resp, 5'b10111);
            check("bp_mask_stable", respMask, 4'b0100);
            check("bp_req_ready", reqReady, 0);
            check("bp_no_ac", acValid, 0);
        end
        nextCycle(); respReady = 1'b1; #1;
        check("bp_release_valid", respValid, 1);
        check("bp_release_req_ready", reqReady, 0);
        nextCycle(); respReady = 1'b0;
        crValid = 4'b0011; crResp = {5'b00000, 5'b00000, 5'b10000, 5'b00001};
        #1;
        check("bp_idle_valid", respValid, 0);
        check("bp_second_accept", reqReady, 1);
        nextCycle(); reqValid = 1'b0; #1;
        check("second_ac_valid", acValid, 4'b0111);
        check("second_ac_addr", acAddr, 64'h2000);
        check("second_ac_snoop", acSnoop, 4'b1001);
        check("second_ac_prot", acProt, 3'b100);
        nextCycle(); #1;
        check("second_cr_ready", crReady, 4'b0111);
        nextCycle(); #1;
        check("second_two_of_three", crReady, 4'b0100);

        // Reset mid-SNOOP
        rstN = 1'b0; #1;
        check("mrst_req_ready", reqReady, 1);
        check("mrst_ac_valid", acValid, 0);
        check("mrst_cr_ready", crReady, 0);
        check("mrst_resp_valid", respValid, 0);
        check("mrst_resp", resp, 0);
        check("mrst_mask", respMask, 0);
        check("mrst_ac_addr", acAddr, 0);
        check("mrst_ac_snoop", acSnoop, 0);
        nextCycle(); nextCycle();
        rstN = 1'b1;

        // Fresh snoop after reset: accumulator must start clean
        reqValid = 1'b1; reqInit = 2'd3; reqAddr = 64'h5000; reqSnoop = 4'b0001; reqProt = 3'b000;
        crValid = 4'hF; crResp = {5'b11111, 5'b00000, 5'b01000, 5'b00000};
        #1;
        check("fresh_accept_ready", reqReady, 1);
        nextCycle(); reqValid = 1'b0; #1;
        check("fresh_ac_valid", acValid, 4'b0111);
        nextCycle(); #1;
        check("fresh_cr_ready", crReady, 4'b0111);
        nextCycle(); #1;
        check("fresh_resp_wait", respValid, 0);
        nextCycle(); respReady = 1'b1; #1;
        check("fresh_resp_valid", respValid, 1);
        check("fresh_resp", resp, 5'b01000);
        check("fresh_mask", respMask, 4'b0000);
        nextCycle(); respReady = 1'b0; #1;
        check("fresh_idle", respValid, 0);

        // NoPorts=1: no peers, immediate empty response
        req1Valid = 1'b1; req1Init = 1'b0; req1Addr = 64'h7000;
        #1;
        check("p1_accept_ready", req1Ready, 1);
        check("p1_ac_valid_c0", ac1Valid, 0);
        nextCycle(); req1Valid = 1'b0; #1;
        check("p1_resp_valid", resp1Valid, 1);
        check("p1_resp", resp1, 0);
        check("p1_mask", resp1Mask, 0);
        check("p1_ac_valid", ac1Valid, 0);
        check("p1_cr_ready", cr1Ready, 0);
        check("p1_req_ready_busy", req1Ready, 0);
        resp1Ready = 1'b1;
        nextCycle(); resp1Ready = 1'b0; #1;
        check("p1_back_idle", resp1Valid, 0);
        check("p1_idle_ready", req1Ready, 1);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
